// File: rtl/r2r_sar_adc_ctrl.sv
// SAR ADC controller driving an external R2R ladder against a board comparator.
// Define SAR_CONTINUOUS_EN for free-running back-to-back conversions.
module r2r_sar_adc_ctrl #(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 1000,
   parameter int SYNC_STAGES   = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             start,
   input  logic             comparator_in,
   output logic [WIDTH-1:0] R2R_out,
   output logic [WIDTH-1:0] adc_data,
   output logic             data_valid,
   output logic             busy
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [IDX_W-1:0] IDX_MSB   = IDX_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [WIDTH-1:0] TRIAL_MSB = {1'b1, {(WIDTH-1){1'b0}}};

   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("SYNC_STAGES must be at least 2");
      end
      if (SETTLE_CYCLES < SYNC_STAGES) begin : g_bad_settle
         $error("SETTLE_CYCLES must be >= SYNC_STAGES");
      end
   endgenerate

   // Async assert, sync deassert of the internal reset
   logic [1:0] rst_q;
   logic       rst_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_q <= '0;
      else          rst_q <= {rst_q[0], 1'b1};
   end

   assign rst_n = rst_q[1];

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   comp_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], comparator_in};
   end

   assign comp_s = sync_q[SYNC_STAGES-1];

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] trial_q, trial_d;
   logic [IDX_W-1:0] idx_q, idx_d, idx_m1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] adc_q, adc_d;
   logic [WIDTH-1:0] r2r_q, r2r_d;
   logic             dv_q, dv_d;
   logic             busy_q, busy_d;

   assign idx_m1 = idx_q - 1'b1;

   always_comb begin
      state_d = state_q;
      trial_d = trial_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      adc_d   = adc_q;
      dv_d    = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_SETTLE;
                  trial_d = TRIAL_MSB;
                  idx_d   = IDX_MSB;
                  cnt_d   = '0;
               end
            end
            ST_SETTLE: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_SAMPLE;
                  cnt_d   = '0;
               end
            end
            ST_SAMPLE: begin
               if (!comp_s) trial_d[idx_q] = 1'b0;
               if (idx_q == '0) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d           = idx_m1;
                  trial_d[idx_m1] = 1'b1;
                  cnt_d           = '0;
                  state_d         = ST_SETTLE;
               end
            end
            ST_DONE: begin
               adc_d = trial_q;
               dv_d  = 1'b1;
`ifdef SAR_CONTINUOUS_EN
               state_d = ST_SETTLE;
               trial_d = TRIAL_MSB;
               idx_d   = IDX_MSB;
               cnt_d   = '0;
`else
               state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d = (state_d != ST_IDLE);
      r2r_d  = busy_d ? trial_d : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         trial_q <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         adc_q   <= '0;
         r2r_q   <= '0;
         dv_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         trial_q <= trial_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         adc_q   <= adc_d;
         r2r_q   <= r2r_d;
         dv_q    <= dv_d;
         busy_q  <= busy_d;
      end
   end

   assign R2R_out    = r2r_q;
   assign adc_data   = adc_q;
   assign data_valid = dv_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_r2r_sar_adc_ctrl.sv
// Bench for r2r_sar_adc_ctrl with an ideal comparator model.
// Results are tracked through an expected-result queue.
module tb_r2r_sar_adc_ctrl;

   localparam int W   = 8;
   localparam int SC  = 4;
   localparam int LAT = W * (SC + 1) + 1;

   typedef struct {
      logic [7:0] code;
      int         cyc;
   } exp_t;

   typedef struct {
      logic [7:0] vin;
      logic [7:0] exp;
   } vec_t;

   logic         clk;
   logic         reset_n;
   logic         enable;
   logic         start;
   logic         comparator_in;
   logic [W-1:0] R2R_out;
   logic [W-1:0] adc_data;
   logic         data_valid;
   logic         busy;
   logic [7:0]   vin_code;

   int   cyc;
   int   checks;
   int   errors;
   exp_t q[$];

   r2r_sar_adc_ctrl #(
      .WIDTH        (W),
      .SETTLE_CYCLES(SC),
      .SYNC_STAGES  (2)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .start        (start),
      .comparator_in(comparator_in),
      .R2R_out      (R2R_out),
      .adc_data     (adc_data),
      .data_valid   (data_valid),
      .busy         (busy)
   );

   assign comparator_in = (vin_code >= R2R_out);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start(input bit push, input logic [7:0] code,
                              output int n);
      start = 1'b1;
      n = cyc + 1;
      if (push) q.push_back('{code: code, cyc: n + LAT});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_until(input int t);
      int g;
      g = 0;
      while (cyc < t && g < 500) begin
         @(negedge clk);
         g++;
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (q.size() != 0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk("drain", q.size(), 0);
      @(negedge clk);
      chk("busy_after", {31'd0, busy}, 0);
   endtask

   vec_t       vecs[6];
   logic [7:0] seq[8];
   int         n0;
   int         nd;
   bit         prev_dv;

   initial begin
      cyc      = 0;
      checks   = 0;
      errors   = 0;
      prev_dv  = 1'b0;
      reset_n  = 1'b0;
      enable   = 1'b0;
      start    = 1'b0;
      vin_code = 8'h00;

      vecs[0] = '{vin: 8'hA5, exp: 8'hA5};
      vecs[1] = '{vin: 8'h00, exp: 8'h00};
      vecs[2] = '{vin: 8'h7E, exp: 8'h7E};
      vecs[3] = '{vin: 8'h01, exp: 8'h01};
      vecs[4] = '{vin: 8'h80, exp: 8'h80};
      vecs[5] = '{vin: 8'hFF, exp: 8'hFF};
      seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

      fork
         forever begin
            @(negedge clk);
            if (reset_n && data_valid) begin
               checks++;
               if (prev_dv) begin
                  errors++;
                  $display("FAIL dv_double at cyc %0d", cyc);
               end else if (q.size() == 0) begin
                  errors++;
                  $display("FAIL dv_unexpected adc %0h at cyc %0d",
                           adc_data, cyc);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  if (adc_data !== e.code || cyc != e.cyc) begin
                     errors++;
                     $display("FAIL dv_result got %0h@%0d want %0h@%0d",
                              adc_data, cyc, e.code, e.cyc);
                  end
               end
            end
            prev_dv = reset_n && data_valid;
         end
      join_none

      repeat (3) @(negedge clk);
      chk("rst_r2r", {24'd0, R2R_out}, 0);
      chk("rst_adc", {24'd0, adc_data}, 0);
      chk("rst_dv", {31'd0, data_valid}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      enable = 1'b1;
      @(negedge clk);

`ifdef SAR_CONTINUOUS_EN
      vin_code = 8'h71;
      pulse_start(1'b1, 8'h71, n0);
      q.push_back('{code: 8'h0E, cyc: n0 + 2 * LAT});
      wait_until(n0 + LAT - 1);
      vin_code = 8'h0E;
      @(negedge clk);
      chk("cont_busy", {31'd0, busy}, 1);
      wait_until(n0 + 2 * LAT);
      enable = 1'b0;
      drain();
      repeat (60) @(negedge clk);
      chk("cont_idle_r2r", {24'd0, R2R_out}, 0);
`else
      for (int i = 0; i < 6; i++) begin
         vin_code = vecs[i].vin;
         pulse_start(1'b1, vecs[i].exp, n0);
         if (i == 0) begin
            for (int k = 0; k < 8; k++) begin
               wait_until(n0 + 5 * k);
               chk("trial_seq", {24'd0, R2R_out}, {24'd0, seq[k]});
            end
         end
         drain();
      end

      vin_code = 8'h3C;
      pulse_start(1'b0, 8'h00, n0);
      wait_until(n0 + 12);
      enable = 1'b0;
      @(negedge clk);
      chk("abort_r2r", {24'd0, R2R_out}, 0);
      chk("abort_busy", {31'd0, busy}, 0);
      chk("abort_adc", {24'd0, adc_data}, 32'hFF);
      repeat (50) @(negedge clk);
      chk("abort_keep", {24'd0, adc_data}, 32'hFF);
      enable = 1'b1;
      @(negedge clk);
      pulse_start(1'b1, 8'h3C, n0);
      drain();

      vin_code = 8'h33;
      pulse_start(1'b1, 8'h33, n0);
      wait_until(n0 + 9);
      pulse_start(1'b0, 8'h00, nd);
      chk("busy_mid", {31'd0, busy}, 1);
      drain();
      repeat (60) @(negedge clk);

      vin_code = 8'h5A;
      pulse_start(1'b1, 8'h5A, n0);
      wait_until(n0 + 19);
      reset_n = 1'b0;
      #1;
      chk("mrst_r2r", {24'd0, R2R_out}, 0);
      chk("mrst_adc", {24'd0, adc_data}, 0);
      chk("mrst_dv", {31'd0, data_valid}, 0);
      chk("mrst_busy", {31'd0, busy}, 0);
      q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      pulse_start(1'b1, 8'h5A, n0);
      drain();
`endif

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
